// File: rtl/alu_result_buffer_if.sv
// alu_result_buffer_if: ALU-side handshake and CDB-side request/grant bundle for alu_result_buffer
interface alu_result_buffer_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W = 6,
  parameter int DEPTH = 4
);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] in_data;
  logic [TAG_W-1:0] in_tag;
  logic in_ovf;
  logic cdb_req;
  logic cdb_grant;
  logic [DATA_W-1:0] cdb_data;
  logic [TAG_W-1:0] cdb_tag;
  logic cdb_ovf;
  logic [$clog2(DEPTH):0] count;
  modport master (
    output flush, in_valid, in_data, in_tag, in_ovf, cdb_grant,
    input in_ready, cdb_req, cdb_data, cdb_tag, cdb_ovf, count
  );
  modport slave (
    input flush, in_valid, in_data, in_tag, in_ovf, cdb_grant,
    output in_ready, cdb_req, cdb_data, cdb_tag, cdb_ovf, count
  );
endinterface

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: circular FIFO of ALU results awaiting the CDB, flushable on mispredict.
// Define ALU_RESULT_BYPASS_EN to forward a result straight to the CDB when the buffer is empty.
module alu_result_buffer #(
  parameter int DATA_W = 32,
  parameter int TAG_W = 6,
  parameter int DEPTH = 4
) (
  input logic clock,
  input logic reset,
  alu_result_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_W + TAG_W + 1;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic empty, full, push, pop;
  logic [EW-1:0] head;
  always_comb begin
    empty = count == '0;
    full = count == (AW+1)'(DEPTH);
    bus.in_ready = ~full;
    bus.count = count;
    pop = ~empty & ~bus.flush & bus.cdb_grant;
`ifdef ALU_RESULT_BYPASS_EN
    // An empty buffer forwards the live input; a granted forward never enters storage.
    bus.cdb_req = ~bus.flush & (~empty | bus.in_valid);
    head = ~empty ? mem[rd_ptr] : bus.flush ? '0 : {bus.in_data, bus.in_tag, bus.in_ovf};
    push = bus.in_valid & ~full & ~bus.flush & ~(empty & bus.cdb_grant);
`else
    bus.cdb_req = ~empty & ~bus.flush;
    head = empty ? '0 : mem[rd_ptr];
    push = bus.in_valid & ~full & ~bus.flush;
`endif
    {bus.cdb_data, bus.cdb_tag, bus.cdb_ovf} = head;
  end
  always_ff @(posedge clock) begin
    if (reset || bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {bus.in_data, bus.in_tag, bus.in_ovf};
  end
endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: queue-model scoreboard for alu_result_buffer with directed and random traffic
module tb_alu_result_buffer;
  localparam int DATA_W = 32;
  localparam int TAG_W = 6;
  localparam int DEPTH = 4;
  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [TAG_W-1:0] t;
    logic o;
  } ent_t;
  logic clock = 0;
  logic reset = 1;
  alu_result_buffer_if #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) bus ();
  alu_result_buffer #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 clock = ~clock;
  ent_t q[$];
  logic [TAG_W-1:0] dut_tags[$];
  int errors = 0;
  int checks = 0;
  bit armed = 0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference model: a plain queue of accepted results, updated from pre-edge inputs.
  always @(posedge clock) begin : model
    int n;
    bit do_pop, do_push;
    ent_t e;
    if (reset) begin
      q.delete();
      armed = 1;
    end else if (bus.flush) begin
      q.delete();
    end else begin
      n = q.size();
      e = '{bus.in_data, bus.in_tag, bus.in_ovf};
      do_pop = bus.cdb_grant && n > 0;
      do_push = bus.in_valid && n < DEPTH;
`ifdef ALU_RESULT_BYPASS_EN
      if (n == 0 && bus.in_valid && bus.cdb_grant) do_push = 0;
`endif
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
  end
  always @(negedge clock) begin : monitor
    ent_t h;
    bit e;
    bit req;
    if (armed) begin
      e = q.size() == 0;
      h = e ? '0 : q[0];
      req = !e && !bus.flush;
`ifdef ALU_RESULT_BYPASS_EN
      if (e && !bus.flush) begin
        h = '{bus.in_data, bus.in_tag, bus.in_ovf};
        req = bus.in_valid;
      end
`endif
      chk("count", bus.count, q.size());
      chk("in_ready", bus.in_ready, q.size() < DEPTH);
      chk("cdb_req", bus.cdb_req, req);
      chk("cdb_head", {bus.cdb_data, bus.cdb_tag, bus.cdb_ovf}, h);
      if (bus.cdb_req && bus.cdb_grant) dut_tags.push_back(bus.cdb_tag);
    end
  end
  task automatic drive(bit v, logic [DATA_W-1:0] d, logic [TAG_W-1:0] t, bit o, bit g, bit f);
    bus.in_valid = v;
    bus.in_data = d;
    bus.in_tag = t;
    bus.in_ovf = o;
    bus.cdb_grant = g;
    bus.flush = f;
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  initial begin
    drive(0, '0, '0, 0, 0, 0);
    step();
    step();
    reset = 0;
    @(negedge clock);
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_req", bus.cdb_req, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_data", bus.cdb_data, 0);
`ifndef ALU_RESULT_BYPASS_EN
    drive(1, 32'hDEADBEEF, 5, 0, 1, 0);
    step();
    drive(0, '0, '0, 0, 1, 0);
    @(negedge clock);
    chk("t2_req", bus.cdb_req, 1);
    chk("t2_data", bus.cdb_data, 32'hDEADBEEF);
    chk("t2_tag", bus.cdb_tag, 5);
    step();
    @(negedge clock);
    chk("t2_count", bus.count, 0);
`endif
    drive(0, '0, '0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      drive(1, $urandom, TAG_W'(i), 1'($urandom), 0, 0);
      step();
    end
    drive(1, 32'h55, 5, 0, 0, 0);
    step();
    @(negedge clock);
    chk("t3_count", bus.count, 4);
    chk("t3_ready", bus.in_ready, 0);
    dut_tags.delete();
    drive(0, '0, '0, 0, 1, 0);
    repeat (4) step();
    drive(0, '0, '0, 0, 0, 0);
    @(negedge clock);
    chk("t3_npop", dut_tags.size(), 4);
    for (int i = 0; i < 4 && i < dut_tags.size(); i++) chk("t3_order", dut_tags[i], i + 1);
    for (int i = 0; i < 2; i++) begin
      drive(1, $urandom, TAG_W'(10 + i), 0, 0, 0);
      step();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, $urandom, TAG_W'(20 + i), 1'($urandom), 1, 0);
      step();
      @(negedge clock);
      chk("t4_count", bus.count, 2);
    end
    drive(1, $urandom, 7, 0, 0, 0);
    step();
    @(negedge clock);
    chk("t5_pre", bus.count, 3);
    dut_tags.delete();
    drive(1, 32'h1234, 9, 1, 1, 1);
    step();
    drive(0, '0, '0, 0, 0, 0);
    @(negedge clock);
    chk("t5_count", bus.count, 0);
    chk("t5_req", bus.cdb_req, 0);
    chk("t5_nopop", dut_tags.size(), 0);
`ifdef ALU_RESULT_BYPASS_EN
    drive(1, 32'h7, 3, 0, 1, 0);
    @(negedge clock);
    chk("t6_req", bus.cdb_req, 1);
    chk("t6_data", bus.cdb_data, 32'h7);
    step();
    @(negedge clock);
    chk("t6_count0", bus.count, 0);
    drive(1, 32'h7, 3, 0, 0, 0);
    step();
    drive(0, '0, '0, 0, 0, 0);
    @(negedge clock);
    chk("t6_count1", bus.count, 1);
`endif
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom, TAG_W'($urandom), 1'($urandom),
            1'($urandom), $urandom_range(0, 99) < 3);
      reset = $urandom_range(0, 99) < 1;
      step();
    end
    reset = 0;
    drive(0, '0, '0, 0, 1, 0);
    repeat (DEPTH + 1) step();
    @(negedge clock);
    chk("drain_count", bus.count, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
